// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered RV32I/RV32M ALU-control decoder with valid/ready hold and MUL/DIV latency sequencing
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   flush           drop any held or in-flight op, return to IDLE
//   in_valid/in_ready/inst        upstream instruction handshake
//   out_valid/out_ready/alu_ctl/illegal  downstream decoded-op handshake
//   mdu_start       one-cycle pulse when a multiply/divide op begins
//   mdu_busy        high for the whole multi-cycle MDU window
module alu_ctrl_seq #(
  parameter int INST_WIDTH    = 32,
  parameter int ALU_CTL_WIDTH = 5,
  parameter bit ENABLE_M      = 1'b1,
  parameter int MUL_LAT       = 2,
  parameter int DIV_LAT       = 33,
  parameter int CNT_WIDTH     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_CTL_WIDTH-1:0] alu_ctl,
  output logic                     illegal,
  output logic                     mdu_start,
  output logic                     mdu_busy
);
  typedef enum logic [1:0] {IDLE, HOLD, MDU} state_t;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] lat;
  logic [6:0]           op;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [4:0]           code;
  logic [4:0]           base;
  logic                 ill;
  logic                 is_m;
  logic                 accept;
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  // funct3 -> code for the plain (funct7=0) R/I arithmetic slot
  always_comb begin
    base = 5'd0;
    case (f3)
      3'd0: base = 5'd0;
      3'd1: base = 5'd5;
      3'd2: base = 5'd8;
      3'd3: base = 5'd9;
      3'd4: base = 5'd2;
      3'd5: base = 5'd6;
      3'd6: base = 5'd3;
      default: base = 5'd4;
    endcase
  end
  // illegal paths leave code at ADD
  always_comb begin
    code = 5'd0;
    ill  = 1'b0;
    is_m = 1'b0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000) code = base;
        else if (f7 == 7'b0100000 && f3 == 3'd0) code = 5'd1;
        else if (f7 == 7'b0100000 && f3 == 3'd5) code = 5'd7;
        else if (f7 == 7'b0000001 && ENABLE_M) begin
          code = 5'd12 + {2'b00, f3};
          is_m = 1'b1;
        end
        else ill = 1'b1;
      end
      7'b0010011: begin
        if (f3 == 3'd1) begin
          if (f7 == 7'b0000000) code = 5'd5;
          else ill = 1'b1;
        end
        else if (f3 == 3'd5) begin
          if (f7 == 7'b0000000) code = 5'd6;
          else if (f7 == 7'b0100000) code = 5'd7;
          else ill = 1'b1;
        end
        else code = base;
      end
      7'b0000011: ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      7'b0100011: ill = f3[2] || (f3 == 3'd3);
      7'b0010111: code = 5'd0;
      7'b1100011: begin
        if (f3[2:1] == 2'b00) code = 5'd1;
        else if (f3[2:1] == 2'b10) code = 5'd8;
        else if (f3[2:1] == 2'b11) code = 5'd9;
        else ill = 1'b1;
      end
      7'b1101111: code = 5'd10;
      7'b1100111: begin
        if (f3 == 3'd0) code = 5'd10;
        else ill = 1'b1;
      end
      7'b0110111: code = 5'd11;
      default: ill = 1'b1;
    endcase
  end
  // funct3[2] separates DIV/REM from MUL within the M group
  assign lat      = f3[2] ? CNT_WIDTH'(DIV_LAT - 1) : CNT_WIDTH'(MUL_LAT - 1);
  assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready)) & ~flush;
  assign accept   = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_ctl   <= '0;
      illegal   <= 1'b0;
      mdu_start <= 1'b0;
      mdu_busy  <= 1'b0;
    end
    else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      mdu_start <= 1'b0;
      mdu_busy  <= 1'b0;
    end
    else begin
      mdu_start <= 1'b0;
      if (accept) begin
        alu_ctl   <= ALU_CTL_WIDTH'(code);
        illegal   <= ill;
        state     <= is_m ? MDU : HOLD;
        out_valid <= ~is_m;
        mdu_start <= is_m;
        mdu_busy  <= is_m;
        cnt       <= is_m ? lat : '0;
      end
      else if (state == HOLD && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
      else if (state == MDU) begin
        if (cnt == '0) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          mdu_busy  <= 1'b0;
        end
        else cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for alu_ctrl_seq with an RV32M and a no-M instance
module tb_alu_ctrl_seq;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic        in_ready, out_valid, illegal, mdu_start, mdu_busy;
  logic [4:0]  alu_ctl;
  logic        flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [31:0] inst2 = '0;
  logic        in_ready2, out_valid2, illegal2, mdu_start2, mdu_busy2;
  logic [4:0]  alu_ctl2;
  typedef struct packed {logic [4:0] c; logic i;} exp_t;
  typedef struct packed {logic [31:0] ins; logic [4:0] c; logic i;} vec_t;
  exp_t q[$], q2[$];
  exp_t e_m, e_m2;
  int checks = 0, errors = 0, xfers = 0;
  vec_t vt [24] = '{
    '{32'h40000033, 5'd1,  1'b0}, '{32'h00001033, 5'd5,  1'b0}, '{32'h00002033, 5'd8,  1'b0},
    '{32'h00003033, 5'd9,  1'b0}, '{32'h00004033, 5'd2,  1'b0}, '{32'h00005033, 5'd6,  1'b0},
    '{32'h00006033, 5'd3,  1'b0}, '{32'h00007033, 5'd4,  1'b0}, '{32'h40005013, 5'd7,  1'b0},
    '{32'h40001013, 5'd0,  1'b1}, '{32'h00002003, 5'd0,  1'b0}, '{32'h00002023, 5'd0,  1'b0},
    '{32'h00003003, 5'd0,  1'b1}, '{32'h00000017, 5'd0,  1'b0}, '{32'h00001063, 5'd1,  1'b0},
    '{32'h00004063, 5'd8,  1'b0}, '{32'h00007063, 5'd9,  1'b0}, '{32'h00002063, 5'd0,  1'b1},
    '{32'h0000006F, 5'd10, 1'b0}, '{32'h00000067, 5'd10, 1'b0}, '{32'h00000037, 5'd11, 1'b0},
    '{32'h02003033, 5'd15, 1'b0}, '{32'h02007033, 5'd19, 1'b0}, '{32'h80000033, 5'd0,  1'b1}
  };
  alu_ctrl_seq u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
    .illegal(illegal), .mdu_start(mdu_start), .mdu_busy(mdu_busy)
  );
  alu_ctrl_seq #(.ENABLE_M(1'b0)) u_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .inst(inst2), .out_valid(out_valid2), .out_ready(out_ready2), .alu_ctl(alu_ctl2),
    .illegal(illegal2), .mdu_start(mdu_start2), .mdu_busy(mdu_busy2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", q.size(), 1);
      else begin
        e_m = q.pop_front();
        chk("alu_ctl", alu_ctl, e_m.c);
        chk("illegal", illegal, e_m.i);
        xfers++;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      if (q2.size() == 0) chk("nom_unexpected_out", q2.size(), 1);
      else begin
        e_m2 = q2.pop_front();
        chk("nom_alu_ctl", alu_ctl2, e_m2.c);
        chk("nom_illegal", illegal2, e_m2.i);
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] ins, input logic [4:0] c, input logic i, output int waits);
    in_valid = 1'b1;
    inst = ins;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", waits, 0);
    else q.push_back(exp_t'({c, i}));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic send2(input logic [31:0] ins, input logic [4:0] c, input logic i);
    int waits;
    in_valid2 = 1'b1;
    inst2 = ins;
    waits = 0;
    @(negedge clk);
    while (!in_ready2 && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready2) chk("nom_accept_timeout", waits, 0);
    else q2.push_back(exp_t'({c, i}));
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask
  task automatic measure(output int starts, output int busy, output int rise);
    starts = 0;
    busy = 0;
    rise = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) chk("mdu_in_ready", in_ready, 0);
      starts += int'(mdu_start);
      busy += int'(mdu_busy);
      if (out_valid) begin
        rise = k;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int k = 0; k < 300 && (q.size() != 0 || q2.size() != 0); k++) @(posedge clk);
    #1;
    chk("drain", q.size() + q2.size(), 0);
  endtask
  initial begin
    int w, starts, busy, rise, base;
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctl", alu_ctl, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_mdu_busy", mdu_busy, 0);
    chk("rst_mdu_start", mdu_start, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h003100B3, 5'd0, 1'b0, w);
    chk("add_wait", w, 0);
    chk("add_out_valid", out_valid, 1);
    idle(1);
    out_ready = 1'b0;
    send(32'h403150B3, 5'd7, 1'b0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sra_hold_valid", out_valid, 1);
      chk("sra_hold_ctl", alu_ctl, 7);
      chk("sra_hold_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(1);
    send(32'h0220C0B3, 5'd16, 1'b0, w);
    measure(starts, busy, rise);
    chk("div_starts", starts, 1);
    chk("div_busy", busy, 33);
    chk("div_rise", rise, 34);
    send(32'h023100B3, 5'd12, 1'b0, w);
    measure(starts, busy, rise);
    chk("mul_starts", starts, 1);
    chk("mul_busy", busy, 2);
    chk("mul_rise", rise, 3);
    send(32'h0000007F, 5'd0, 1'b1, w);
    foreach (vt[j]) send(vt[j].ins, vt[j].c, vt[j].i, w);
    drain();
    send(32'h0220C0B3, 5'd16, 1'b0, w);
    idle(4);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", in_ready, 0);
    chk("flush_busy_before", mdu_busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_busy", mdu_busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    idle(40);
    base = xfers;
    for (int k = 1; k <= 4; k++) begin
      send(32'h00008093 | (k << 20), 5'd0, 1'b0, w);
      chk("stream_wait", w, 0);
    end
    @(negedge clk);
    #1;
    chk("stream_xfers", xfers - base, 4);
    idle(1);
    send(32'h0010E093, 5'd3, 1'b0, w);
    send(32'h0020E093, 5'd3, 1'b0, w);
    rst_n = 1'b0;
    idle(1);
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_alu_ctl", alu_ctl, 0);
    chk("midrst_in_ready", in_ready, 0);
    idle(1);
    rst_n = 1'b1;
    send(32'h0220C0B3, 5'd16, 1'b0, w);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    q.delete();
    rst_n = 1'b1;
    starts = 0;
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      starts += int'(mdu_start);
      busy += int'(mdu_busy);
    end
    chk("mdurst_starts", starts, 0);
    chk("mdurst_busy", busy, 0);
    idle(1);
    send2(32'h023100B3, 5'd0, 1'b1);
    chk("nom_mul_valid", out_valid2, 1);
    chk("nom_mul_busy", mdu_busy2, 0);
    send2(32'h0000007F, 5'd0, 1'b1);
    send2(32'h003100B3, 5'd0, 1'b0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
